// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART command decoder and its reply sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package uart_cmd_pkg;

    typedef logic [2:0] state_t;

    // The top-level controller uses IDLE..WAIT_RESP and SEND0 for the whole
    // reply phase; the reply sequencer walks SEND0..WAIT1 itself.
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_GET_ADDR  = 3'd1;
    localparam state_t S_ISSUE     = 3'd2;
    localparam state_t S_WAIT_RESP = 3'd3;
    localparam state_t S_SEND0     = 3'd4;
    localparam state_t S_WAIT0     = 3'd5;
    localparam state_t S_SEND1     = 3'd6;
    localparam state_t S_WAIT1     = 3'd7;

    localparam logic [7:0] ST_BADCMD  = 8'hEE;
    localparam logic [7:0] ST_TIMEOUT = 8'hFF;

    localparam logic [7:0] CMD_MIN_DEF = 8'h01;
    localparam logic [7:0] CMD_MAX_DEF = 8'h03;

    function automatic logic inRange(input logic [7:0] v,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// Sends a 2-byte reply {byte0, byte1} through the UART transmitter.
// Latency: start -> first txStart 1 cycle when txBusy=0; second byte only after txDone.
// Backpressure: each byte waits in SEND while txBusy=1; WAIT holds txData until txDone.
// Ports: clk, rstN; start (1-cycle kick), byte0/byte1 (held stable by caller
// for the whole reply), txBusy/txDone from the transmitter; txStart/txData to
// the transmitter; done pulses with the txDone that ends the second byte.
module uart_tx_seq
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic       start,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    input  logic       txBusy,
    input  logic       txDone,
    output logic       txStart,
    output logic [7:0] txData,
    output logic       done
);

    state_t seqState;
    state_t seqNext;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) seqState <= S_IDLE;
        else       seqState <= seqNext;
    end

    always_comb begin
        seqNext = seqState;
        case (seqState)
            S_IDLE:  if (start)   seqNext = S_SEND0;
            S_SEND0: if (!txBusy) seqNext = S_WAIT0;
            S_WAIT0: if (txDone)  seqNext = S_SEND1;
            S_SEND1: if (!txBusy) seqNext = S_WAIT1;
            S_WAIT1: if (txDone)  seqNext = S_IDLE;
            default:              seqNext = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state register, so an async reset
    // drops txStart in the same instant.
    always_comb begin
        txStart = 1'b0;
        txData  = 8'h00;
        done    = 1'b0;
        case (seqState)
            S_SEND0: begin
                txStart = !txBusy;
                txData  = byte0;
            end
            S_WAIT0: txData = byte0;
            S_SEND1: begin
                txStart = !txBusy;
                txData  = byte1;
            end
            S_WAIT1: begin
                txData = byte1;
                done   = txDone;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles {cmd, addr} UART frames, issues one peripheral request, replies {status, data}.
// Latency: last rx byte -> reqValid 1 cycle; respValid or bad frame -> first txStart 1 cycle.
// Backpressure: reqValid held until reqReady; reply waits on txBusy; rx bytes outside a frame are dropped.
// Ports: clk, rstN; rxData/rxDone from the UART receiver; txData/txStart to
// the transmitter with txBusy/txDone back; reqValid/reqCmd/reqAddr with
// reqReady on the request side; respValid/respStatus/respData on the result
// side; busy (not idle) and frameErr (timeout or dropped byte) status.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int         CLOCK_RATE  = 50000000,
    parameter int         BYTE_TO_CYC = CLOCK_RATE / 1000,
    parameter int         RESP_TO_CYC = CLOCK_RATE / 100,
    parameter logic [7:0] CMD_MIN     = CMD_MIN_DEF,
    parameter logic [7:0] CMD_MAX     = CMD_MAX_DEF,
    parameter int         ADDR_MAX    = 31
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [7:0] rxData,
    input  logic       rxDone,
    output logic [7:0] txData,
    output logic       txStart,
    input  logic       txBusy,
    input  logic       txDone,
    output logic       reqValid,
    output logic [7:0] reqCmd,
    output logic [4:0] reqAddr,
    input  logic       reqReady,
    input  logic       respValid,
    input  logic [7:0] respStatus,
    input  logic [7:0] respData,
    output logic       busy,
    output logic       frameErr
);

    localparam int            TW        = $clog2(RESP_TO_CYC) + 1;
    localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TO_CYC - 1);
    localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TO_CYC - 1);
    localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};

    state_t        state;
    state_t        stateNext;
    logic [TW-1:0] timer;
    logic [7:0]    cmdReg;
    logic [4:0]    addrReg;
    logic [7:0]    stReg;
    logic [7:0]    dtReg;
    logic          frameOk;
    logic          byteTimeout;
    logic          respTimeout;
    logic          seqStart;
    logic          seqDone;

    // Evaluated in the cycle the address byte arrives, against the raw byte.
    assign frameOk     = inRange(cmdReg, CMD_MIN, CMD_MAX) && (rxData <= 8'(ADDR_MAX));
    assign byteTimeout = (state == S_GET_ADDR)  && (timer == BYTE_LAST);
    assign respTimeout = (state == S_WAIT_RESP) && (timer == RESP_LAST);

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= S_IDLE;
        else       state <= stateNext;
    end

    // Next-state logic. A received byte beats the inter-byte timeout and a
    // response beats the response timeout when they land in the same cycle.
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE: if (rxDone) stateNext = S_GET_ADDR;
            S_GET_ADDR: begin
                if (rxDone)           stateNext = frameOk ? S_ISSUE : S_SEND0;
                else if (byteTimeout) stateNext = S_IDLE;
            end
            S_ISSUE: if (reqReady) stateNext = S_WAIT_RESP;
            S_WAIT_RESP: if (respValid || respTimeout) stateNext = S_SEND0;
            // S_SEND0 here stands for the whole reply; the sequencer owns
            // the per-byte SEND/WAIT steps.
            S_SEND0: if (seqDone) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        reqValid = (state == S_ISSUE);
        busy     = (state != S_IDLE);
        seqStart = (state != S_SEND0) && (stateNext == S_SEND0);
        frameErr = (byteTimeout && !rxDone)
                || (rxDone && (state != S_IDLE) && (state != S_GET_ADDR));
    end

    // Timer restarts on every state change and saturates instead of wrapping.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                  timer <= '0;
        else if (stateNext != state) timer <= '0;
        else if (timer != TIMER_MAX) timer <= timer + 1'b1;
    end

    // Frame and reply registers. stReg/dtReg stay put for the whole reply,
    // which is what lets the sequencer use them without its own copy.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cmdReg  <= 8'h00;
            addrReg <= 5'd0;
            stReg   <= 8'h00;
            dtReg   <= 8'h00;
        end else begin
            case (state)
                S_IDLE: if (rxDone) cmdReg <= rxData;
                S_GET_ADDR: begin
                    if (rxDone) begin
                        addrReg <= rxData[4:0];
                        if (!frameOk) begin
                            stReg <= ST_BADCMD;
                            dtReg <= rxData;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (respValid) begin
                        stReg <= respStatus;
                        dtReg <= respData;
                    end else if (respTimeout) begin
                        stReg <= ST_TIMEOUT;
                        dtReg <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign reqCmd  = cmdReg;
    assign reqAddr = addrReg;

    uart_tx_seq uTxSeq (
        .clk     (clk),
        .rstN    (rstN),
        .start   (seqStart),
        .byte0   (stReg),
        .byte1   (dtReg),
        .txBusy  (txBusy),
        .txDone  (txDone),
        .txStart (txStart),
        .txData  (txData),
        .done    (seqDone)
    );

endmodule
